// File: rtl/uart_tx_param_pkg.sv
// Shared definitions for the parametrised UART transmitter: parity modes,
// frame FSM states and a counter-width helper.
package uart_tx_param_pkg;

  localparam int unsigned PAR_NONE = 0;
  localparam int unsigned PAR_ODD  = 1;
  localparam int unsigned PAR_EVEN = 2;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_PAR,
    ST_STOP
  } tx_state_e;

  // Width able to hold 0..n-1, never narrower than one bit.
  function automatic int unsigned cnt_width(input int unsigned n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/uart_baud_tick.sv
// Bit-period timer: pulses bit_tick_o on the last cycle of every bit period.
// restart_i holds the phase at zero so the first bit starts at acceptance.
module uart_baud_tick
  import uart_tx_param_pkg::*;
#(
  parameter int unsigned BIT_CYC = 10
) (
  input  logic clk,
  input  logic rst_n,
  input  logic restart_i,
  output logic bit_tick_o
);

  localparam int unsigned CW = cnt_width(BIT_CYC);

  logic [CW-1:0] cnt_q, cnt_d;

  assign bit_tick_o = !restart_i && (cnt_q == CW'(BIT_CYC - 1));

  always_comb begin
    cnt_d = cnt_q + CW'(1);
    if (restart_i || bit_tick_o) begin
      cnt_d = '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/uart_tx_param.sv
// Parametrised UART transmitter: valid/ready word input, start/data/parity/stop
// framing on a registered idle-high line, one-cycle tx_done after each frame.
module uart_tx_param
  import uart_tx_param_pkg::*;
#(
  parameter int unsigned CLK_FREQ  = 50_000_000,
  parameter int unsigned BAUD      = 115_200,
  parameter int unsigned DATA_W    = 8,
  parameter int unsigned PARITY    = 0,
  parameter int unsigned STOP_BITS = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              tx_valid,
  input  logic [DATA_W-1:0] tx_data,
  output logic              tx_ready,
  output logic              tx,
  output logic              busy,
  output logic              tx_done
);

  localparam int unsigned BIT_CYC = CLK_FREQ / BAUD;
  localparam int unsigned BW      = cnt_width(DATA_W + 1);

  if (BIT_CYC < 2) begin : g_bit_cyc_chk
    $error("uart_tx_param: CLK_FREQ/BAUD must be at least 2");
  end
  if (DATA_W < 5 || DATA_W > 9) begin : g_data_w_chk
    $error("uart_tx_param: DATA_W must be 5..9");
  end
  if (PARITY > PAR_EVEN) begin : g_parity_chk
    $error("uart_tx_param: PARITY must be 0, 1 or 2");
  end
  if (STOP_BITS < 1 || STOP_BITS > 2) begin : g_stop_chk
    $error("uart_tx_param: STOP_BITS must be 1 or 2");
  end

  tx_state_e         state_q, state_d;
  logic [DATA_W-1:0] shift_q, shift_d;
  logic [BW-1:0]     bit_q, bit_d;
  logic              par_q, par_d;
  logic              tx_q, tx_d;
  logic              done_q, done_d;
  logic              bit_tick;
  logic              restart;

  assign restart = (state_q == ST_IDLE);

  uart_baud_tick #(
    .BIT_CYC(BIT_CYC)
  ) u_baud_tick (
    .clk       (clk),
    .rst_n     (rst_n),
    .restart_i (restart),
    .bit_tick_o(bit_tick)
  );

  always_comb begin
    state_d = state_q;
    shift_d = shift_q;
    bit_d   = bit_q;
    par_d   = par_q;
    done_d  = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (tx_valid) begin
          state_d = ST_START;
          shift_d = tx_data;
          bit_d   = '0;
          // Odd parity inverts the plain XOR so the total 1s count is odd.
          par_d   = (PARITY == PAR_ODD) ? ~^tx_data : ^tx_data;
        end
      end
      ST_START: begin
        if (bit_tick) state_d = ST_DATA;
      end
      ST_DATA: begin
        if (bit_tick) begin
          shift_d = shift_q >> 1;
          if (bit_q == BW'(DATA_W - 1)) begin
            bit_d   = '0;
            state_d = (PARITY != PAR_NONE) ? ST_PAR : ST_STOP;
          end else begin
            bit_d = bit_q + BW'(1);
          end
        end
      end
      ST_PAR: begin
        if (bit_tick) state_d = ST_STOP;
      end
      ST_STOP: begin
        if (bit_tick) begin
          if (bit_q == BW'(STOP_BITS - 1)) begin
            bit_d   = '0;
            state_d = ST_IDLE;
            done_d  = 1'b1;
          end else begin
            bit_d = bit_q + BW'(1);
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Line level is registered from the current state, so it trails the FSM by one cycle.
  always_comb begin
    tx_d = 1'b1;
    unique case (state_q)
      ST_START: tx_d = 1'b0;
      ST_DATA:  tx_d = shift_q[0];
      ST_PAR:   tx_d = par_q;
      default:  tx_d = 1'b1;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      shift_q <= '0;
      bit_q   <= '0;
      par_q   <= 1'b0;
      tx_q    <= 1'b1;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      shift_q <= shift_d;
      bit_q   <= bit_d;
      par_q   <= par_d;
      tx_q    <= tx_d;
      done_q  <= done_d;
    end
  end

  assign tx_ready = (state_q == ST_IDLE);
  assign busy     = !tx_ready;
  assign tx       = tx_q;
  assign tx_done  = done_q;

endmodule

// File: tb/tb_uart_tx_param.sv
// Bench for uart_tx_param: four configurations (8N1, 8E1, 8O1, 7N2) at BIT_CYC=10,
// each checked every cycle against a frame-timeline model plus literal expectations.
module tb_uart_tx_param;

  logic clk;
  int   n_vec;
  int   n_err;
  int   n_fin;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic int lane_dw(input int g);
    return (g == 3) ? 7 : 8;
  endfunction
  function automatic int lane_par(input int g);
    return (g == 1) ? 2 : ((g == 2) ? 1 : 0);
  endfunction
  function automatic int lane_sb(input int g);
    return (g == 3) ? 2 : 1;
  endfunction
  function automatic logic [8:0] lane_word(input int g);
    return (g == 0) ? 9'h0A5 : ((g == 3) ? 9'h07F : 9'h007);
  endfunction
  // Serial bit k of the frame at bit position k, hand-derived per lane.
  function automatic int lane_bits(input int g);
    case (g)
      0: return 842;
      1: return 1550;
      2: return 1038;
      default: return 1022;
    endcase
  endfunction
  function automatic int lane_c3_bits(input int g);
    case (g)
      0: return 902;
      1: return 1414;
      2: return 1926;
      default: return 902;
    endcase
  endfunction
  function automatic int lane_done(input int g);
    return (g == 1 || g == 2) ? 111 : 101;
  endfunction

  task automatic check(input int lane, input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      if (n_err <= 40)
        $display("FAIL lane%0d %s: got %0h expected %0h at %0t", lane, nm, act, exp, $time);
    end
  endtask

  for (genvar gi = 0; gi < 4; gi++) begin : g_lane
    localparam int DW = lane_dw(gi);
    localparam int PR = lane_par(gi);
    localparam int SB = lane_sb(gi);
    localparam int FB = 1 + DW + ((PR != 0) ? 1 : 0) + SB;
    localparam int L  = FB * 10;

    logic          rst_n;
    logic          valid;
    logic [DW-1:0] data;
    logic          tx, rdy, busy, done;
    logic          en;
    int            t;
    logic [15:0]   bits;
    logic          etx;

    uart_tx_param #(
      .CLK_FREQ (1_000_000),
      .BAUD     (100_000),
      .DATA_W   (DW),
      .PARITY   (PR),
      .STOP_BITS(SB)
    ) dut (
      .clk     (clk),
      .rst_n   (rst_n),
      .tx_valid(valid),
      .tx_data (data),
      .tx_ready(rdy),
      .tx      (tx),
      .busy    (busy),
      .tx_done (done)
    );

    function automatic logic [15:0] mk_bits(input logic [DW-1:0] d);
      logic [15:0] b;
      int ones;
      b = '0;
      ones = 0;
      for (int i = 0; i < DW; i++) begin
        b[1+i] = d[i];
        ones += int'(d[i]);
      end
      if (PR == 2) b[1+DW] = ((ones % 2) == 1);
      if (PR == 1) b[1+DW] = ((ones % 2) == 0);
      for (int i = 0; i < SB; i++) b[FB-SB+i] = 1'b1;
      return b;
    endfunction

    // t = cycles since the accepting edge; line shows frame bit (t-2)/10, done at L+1.
    always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        t <= 0;
      end else if ((t == 0 || t == L + 1) && valid) begin
        t    <= 1;
        bits <= mk_bits(data);
      end else if (t == L + 1) begin
        t <= 0;
      end else if (t != 0) begin
        t <= t + 1;
      end
    end

    always @(negedge clk) begin
      if (en) begin
        etx = (t >= 2 && t <= L + 1) ? bits[(t-2)/10] : 1'b1;
        check(gi, "tx", 32'(tx), 32'(etx));
        check(gi, "tx_ready", 32'(rdy), 32'(t == 0 || t == L + 1));
        check(gi, "busy", 32'(busy), 32'(!(t == 0 || t == L + 1)));
        check(gi, "tx_done", 32'(done), 32'(t == L + 1));
      end
    end

    task automatic wait_idle();
      int c;
      c = 0;
      do begin
        @(negedge clk);
        c++;
      end while (!(rdy === 1'b1 && done === 1'b0) && c < 400);
      check(gi, "idle_reached", 32'(rdy), 32'd1);
    endtask

    task automatic directed(input logic [8:0] w, input int exp_bits, input int exp_done);
      int first_low, done_n, rdy_low;
      logic [15:0] cap;
      check(gi, "model_bits", 32'(mk_bits(DW'(w))), 32'(exp_bits));
      @(negedge clk);
      valid = 1'b1;
      data  = DW'(w);
      @(negedge clk);
      valid = 1'b0;
      first_low = -1;
      done_n = -1;
      rdy_low = 0;
      cap = '0;
      for (int n = 1; n <= 130; n++) begin
        if (n > 1) @(negedge clk);
        if (tx === 1'b0 && first_low < 0) first_low = n;
        if (done === 1'b1 && done_n < 0) done_n = n;
        if (rdy === 1'b0) rdy_low++;
        if (n >= 2 && ((n - 2) % 10) == 5 && ((n - 2) / 10) < FB) cap[(n-2)/10] = tx;
      end
      check(gi, "first_low_cycle", 32'(first_low), 32'd2);
      check(gi, "done_cycle", 32'(done_n), 32'(exp_done));
      check(gi, "ready_low_cycles", 32'(rdy_low), 32'(exp_done - 1));
      check(gi, "captured_bits", 32'(cap), 32'(exp_bits));
    endtask

    task automatic back_to_back(input logic [8:0] w1, input logic [8:0] w2, input int exp_gap);
      int acc0, acc1, na, dones;
      @(negedge clk);
      valid = 1'b1;
      data  = DW'(w1);
      na = 0;
      dones = 0;
      acc0 = 0;
      acc1 = 0;
      for (int c = 0; c < 2 * L + 40; c++) begin
        if (c > 0) @(negedge clk);
        if (na == 1) data = DW'(w2);
        if (na == 2) valid = 1'b0;
        if (done === 1'b1) dones++;
        if (na < 2 && rdy === 1'b1) begin
          if (na == 0) acc0 = c;
          else acc1 = c;
          na++;
        end
      end
      valid = 1'b0;
      check(gi, "b2b_accepts", 32'(na), 32'd2);
      check(gi, "b2b_gap", 32'(acc1 - acc0), 32'(exp_gap));
      check(gi, "b2b_done_pulses", 32'(dones), 32'd2);
    endtask

    task automatic midframe();
      int got;
      @(negedge clk);
      valid = 1'b1;
      data  = DW'($urandom);
      @(negedge clk);
      valid = 1'b0;
      check(gi, "mid_accepted", 32'(busy), 32'd1);
      repeat (30) @(negedge clk);
      data  = DW'($urandom);
      valid = 1'b1;
      check(gi, "mid_not_ready", 32'(rdy), 32'd0);
      @(negedge clk);
      valid = 1'b0;
      data  = DW'($urandom);
      repeat (10) @(negedge clk);
      valid = 1'b1;
      data  = DW'($urandom);
      got = 0;
      for (int c = 0; c < 300 && got == 0; c++) begin
        @(negedge clk);
        if (rdy === 1'b1) got = 1;
      end
      check(gi, "held_word_accepted", 32'(got), 32'd1);
      @(negedge clk);
      valid = 1'b0;
    endtask

    task automatic reset_mid_frame();
      @(negedge clk);
      valid = 1'b1;
      data  = DW'(9'h03C);
      @(negedge clk);
      valid = 1'b0;
      repeat (44) @(negedge clk);
      @(posedge clk);
      #2 rst_n = 1'b0;
      #1;
      check(gi, "rst_tx", 32'(tx), 32'd1);
      check(gi, "rst_busy", 32'(busy), 32'd0);
      check(gi, "rst_ready", 32'(rdy), 32'd1);
      check(gi, "rst_done", 32'(done), 32'd0);
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
    endtask

    initial begin
      logic accn;
      rst_n = 1'b0;
      valid = 1'b0;
      data  = '0;
      en    = 1'b0;
      @(posedge clk);
      #1 en = 1'b1;
      repeat (2) @(negedge clk);
      rst_n = 1'b1;

      directed(lane_word(gi), lane_bits(gi), lane_done(gi));
      wait_idle();
      back_to_back(9'h055, 9'h0AA, lane_done(gi));
      wait_idle();
      midframe();
      wait_idle();
      reset_mid_frame();
      directed(9'h0C3, lane_c3_bits(gi), lane_done(gi));
      wait_idle();

      accn = 1'b0;
      for (int c = 0; c < 3000; c++) begin
        @(negedge clk);
        if (!valid || accn) begin
          valid = ($urandom_range(0, 3) == 0);
          data  = DW'($urandom);
        end
        accn = valid && rdy;
      end
      @(negedge clk);
      valid = 1'b0;
      wait_idle();
      n_fin++;
    end
  end

  initial begin
    int c;
    n_vec = 0;
    n_err = 0;
    n_fin = 0;
    c = 0;
    #1;
    while (n_fin < 4 && c < 60000) begin
      @(posedge clk);
      c++;
    end
    check(99, "lanes_finished", 32'(n_fin), 32'd4);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
